// File: rtl/bouncing_ball_pkg.sv
// Shared constants, direction encoding and arithmetic helpers for the bouncing-ball pixel source.
package bouncing_ball_pkg;

    // Visible area of the VGA timing stage, kept equal to the shared timing constants.
    localparam int H_VISIBLE_AREA = 640;
    localparam int V_VISIBLE_AREA = 480;

    // Beam counters and ball positions are 10 bits; comparisons widen to 11 so they cannot wrap.
    localparam int POS_W  = 10;
    localparam int CALC_W = 11;

    // Direction FSM states: INC moves towards the far edge, DEC towards zero.
    localparam logic [0:0] ST_INC = 1'b0;
    localparam logic [0:0] ST_DEC = 1'b1;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [0:0]       dir;
        logic             bounce;
    } axis_next_t;

    // One movement step of one axis, including reflection at 0 and at the limit.
    function automatic axis_next_t axis_step(
        input logic [POS_W-1:0]  pos,
        input logic [0:0]        dir,
        input logic [CALC_W-1:0] limit,
        input logic [CALC_W-1:0] speed
    );
        axis_next_t       nxt;
        logic [CALC_W-1:0] p;
        p          = CALC_W'(pos);
        nxt.pos    = pos;
        nxt.dir    = dir;
        nxt.bounce = 1'b0;
        if (dir == ST_INC) begin
            if (p + speed >= limit) begin
                nxt.pos    = limit[POS_W-1:0];
                nxt.dir    = ST_DEC;
                nxt.bounce = 1'b1;
            end else begin
                nxt.pos = POS_W'(p + speed);
            end
        end else begin
            if (p <= speed) begin
                nxt.pos    = '0;
                nxt.dir    = ST_INC;
                nxt.bounce = 1'b1;
            end else begin
                nxt.pos = POS_W'(p - speed);
            end
        end
        return nxt;
    endfunction

    // True when v lies in [lo, lo+size), evaluated with one bit of headroom.
    function automatic logic in_span(
        input logic [POS_W-1:0] v,
        input logic [POS_W-1:0] lo,
        input int               size
    );
        logic [CALC_W-1:0] v_w;
        logic [CALC_W-1:0] lo_w;
        v_w  = CALC_W'(v);
        lo_w = CALC_W'(lo);
        return (v_w >= lo_w) && (v_w < lo_w + CALC_W'(size));
    endfunction

endpackage

// File: rtl/bouncing_ball_axis.sv
// One axis of ball motion: position register plus INC/DEC direction FSM, stepped on each tick.
module ball_axis
    import bouncing_ball_pkg::*;
#(
    parameter int p_LIMIT = 624,
    parameter int p_SPEED = 2,
    parameter int p_INIT  = 100
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Tick,
    output logic [POS_W-1:0] o_Pos,
    output logic             o_Bounce
);

    logic [POS_W-1:0] r_pos;
    logic [0:0]       r_state;
    logic             r_bounce;
    axis_next_t       w_next;

    // Candidate next position/direction computed from the current registered state.
    always_comb begin
        w_next = axis_step(r_pos, r_state, CALC_W'(p_LIMIT), CALC_W'(p_SPEED));
    end

    // Commit the step on a tick; the bounce flag is a single-cycle pulse.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_pos    <= POS_W'(p_INIT);
            r_state  <= ST_INC;
            r_bounce <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            if (i_Tick) begin
                r_pos    <= w_next.pos;
                r_state  <= w_next.dir;
                r_bounce <= w_next.bounce;
            end
        end
    end

    assign o_Pos    = r_pos;
    assign o_Bounce = r_bounce;

endmodule

// File: rtl/bouncing_ball.sv
// Ball pixel source: tracks the beam from line/frame reset pulses and renders a moving square.
module bouncing_ball
    import bouncing_ball_pkg::*;
#(
    parameter int p_SIZE     = 16,
    parameter int p_SPEED    = 2,
    parameter int p_FRAMES   = 1,
    parameter int p_X0       = 100,
    parameter int p_Y0       = 50,
    parameter int p_COL_INIT = 1
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_HReset,
    input  logic i_VReset,
    input  logic i_Pause,
    output logic o_Video,
    output logic o_Bounce
);

    localparam logic [3:0]       FC_LAST  = 4'(p_FRAMES - 1);
    localparam logic [POS_W-1:0] COL_INIT = POS_W'(p_COL_INIT);

    logic [POS_W-1:0] r_col;
    logic [POS_W-1:0] r_row;
    logic [3:0]       r_fc;
    logic             r_tick;
    logic             r_video;
    logic             w_tick;
    logic             w_in_ball;
    logic [POS_W-1:0] w_x;
    logic [POS_W-1:0] w_y;
    logic             w_bounce_x;
    logic             w_bounce_y;

    // Beam position: column restarts after each line pulse, row clears on the frame pulse.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_col <= COL_INIT;
            r_row <= '0;
        end else begin
            r_col <= i_HReset ? COL_INIT : r_col + POS_W'(1);
            if (i_VReset) begin
                r_row <= '0;
            end else if (i_HReset) begin
                r_row <= r_row + POS_W'(1);
            end
        end
    end

    // Frame divider: counts every frame (paused or not) and registers an update tick.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_fc   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_VReset) begin
                if (r_fc == FC_LAST) begin
                    r_fc   <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_fc <= r_fc + 4'd1;
                end
            end
        end
    end

    // Pause only masks the movement; the divider keeps its phase.
    assign w_tick = r_tick & ~i_Pause;

    ball_axis #(
        .p_LIMIT (H_VISIBLE_AREA - p_SIZE),
        .p_SPEED (p_SPEED),
        .p_INIT  (p_X0)
    ) u_axis_x (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Tick   (w_tick),
        .o_Pos    (w_x),
        .o_Bounce (w_bounce_x)
    );

    ball_axis #(
        .p_LIMIT (V_VISIBLE_AREA - p_SIZE),
        .p_SPEED (p_SPEED),
        .p_INIT  (p_Y0)
    ) u_axis_y (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Tick   (w_tick),
        .o_Pos    (w_y),
        .o_Bounce (w_bounce_y)
    );

    // Beam-inside-ball test against the current registered position.
    always_comb begin
        w_in_ball = in_span(r_col, w_x, p_SIZE) && in_span(r_row, w_y, p_SIZE);
    end

    // Register the pixel so the output lags its (col, row) by one cycle.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_video <= 1'b0;
        end else begin
            r_video <= w_in_ball;
        end
    end

    assign o_Video  = r_video;
    assign o_Bounce = w_bounce_x | w_bounce_y;

endmodule

// File: tb/tb_bouncing_ball.sv
// Scoreboard bench for bouncing_ball: four instances driven by synthetic line/frame pulse streams.
module tb_bouncing_ball;

    // Lane 0: default ball on 128x72 frames (video checked).
    // Lane 1: p_FRAMES=3 with a pause window.  Lane 2: right-edge bounce.
    // Lane 3: SPEED=7 path that reaches the top-left corner on both axes at once.
    localparam int LEN [4] = '{128, 8, 8, 8};
    localparam int NL  [4] = '{72, 4, 4, 4};
    localparam int NF  [4] = '{5, 19, 4, 93};
    localparam int TOTAL   = 5 * 128 * 72;

    typedef struct {
        int lane;
        int stamp;
        int a;
        int b;
    } exp_t;

    logic i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    logic rstn [4];
    logic hr   [4];
    logic vr   [4];
    logic pau  [4];
    logic vid  [4];
    logic bnc  [4];
    int   st   [4];

    int errors = 0;
    int checks = 0;

    exp_t vq[$];
    exp_t pq[$];
    exp_t bq[$];

    bouncing_ball #(.p_SIZE(16), .p_SPEED(2), .p_FRAMES(1), .p_X0(100), .p_Y0(50), .p_COL_INIT(1)) u_a (
        .i_Clk(i_Clk), .i_Rst_n(rstn[0]), .i_HReset(hr[0]), .i_VReset(vr[0]), .i_Pause(pau[0]),
        .o_Video(vid[0]), .o_Bounce(bnc[0]));
    bouncing_ball #(.p_SIZE(16), .p_SPEED(2), .p_FRAMES(3), .p_X0(100), .p_Y0(50), .p_COL_INIT(1)) u_b (
        .i_Clk(i_Clk), .i_Rst_n(rstn[1]), .i_HReset(hr[1]), .i_VReset(vr[1]), .i_Pause(pau[1]),
        .o_Video(vid[1]), .o_Bounce(bnc[1]));
    bouncing_ball #(.p_SIZE(16), .p_SPEED(2), .p_FRAMES(1), .p_X0(622), .p_Y0(50), .p_COL_INIT(1)) u_c (
        .i_Clk(i_Clk), .i_Rst_n(rstn[2]), .i_HReset(hr[2]), .i_VReset(vr[2]), .i_Pause(pau[2]),
        .o_Video(vid[2]), .o_Bounce(bnc[2]));
    bouncing_ball #(.p_SIZE(16), .p_SPEED(7), .p_FRAMES(1), .p_X0(617), .p_Y0(300), .p_COL_INIT(1)) u_d (
        .i_Clk(i_Clk), .i_Rst_n(rstn[3]), .i_HReset(hr[3]), .i_VReset(vr[3]), .i_Pause(pau[3]),
        .o_Video(vid[3]), .o_Bounce(bnc[3]));

    function automatic int stamp(int f, int l, int k);
        return f * 100000 + l * 1000 + k;
    endfunction

    function automatic int pos_x(int ln);
        case (ln)
            1:       return int'(u_b.w_x);
            2:       return int'(u_c.w_x);
            3:       return int'(u_d.w_x);
            default: return -1;
        endcase
    endfunction

    function automatic int pos_y(int ln);
        case (ln)
            1:       return int'(u_b.w_y);
            2:       return int'(u_c.w_y);
            3:       return int'(u_d.w_y);
            default: return -1;
        endcase
    endfunction

    // Video seen in cycle k of a line describes column k, so a ball at x starts its run at k=x.
    task automatic push_run(int f, int l, int x);
        vq.push_back('{0, stamp(f, l, x), 16, 0});
    endtask

    task automatic push_ball(int f, int x, int y);
        for (int l = y; l < y + 16; l++) push_run(f, l, x);
    endtask

    // New position is visible from cycle 1 of line 0; sampled at cycle 2.
    task automatic push_pos(int ln, int f, int x, int y);
        pq.push_back('{ln, stamp(f, 0, 2), x, y});
    endtask

    // Bounce pulse lands two cycles after the frame pulse: cycle 1 of line 0.
    task automatic push_bnc(int ln, int f);
        bq.push_back('{ln, stamp(f, 0, 1), 0, 0});
    endtask

    task automatic check_run(int got_st, int got_len);
        exp_t e;
        checks++;
        if (vq.size() == 0) begin
            errors++;
            $display("FAIL video_run: unexpected run at stamp %0d len %0d, none expected", got_st, got_len);
        end else begin
            e = vq.pop_front();
            if (got_st != e.stamp) begin
                errors++;
                $display("FAIL video_start: got stamp %0d, want %0d", got_st, e.stamp);
            end
            checks++;
            if (got_len != e.a) begin
                errors++;
                $display("FAIL video_len: at stamp %0d got %0d, want %0d", e.stamp, got_len, e.a);
            end
        end
    endtask

    task automatic check_bounce(int ln);
        int idx;
        idx = -1;
        for (int i = 0; i < bq.size(); i++) begin
            if (bq[i].lane == ln) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL bounce_lane%0d: pulse at stamp %0d, none expected", ln, st[ln]);
        end else begin
            if (st[ln] != bq[idx].stamp) begin
                errors++;
                $display("FAIL bounce_lane%0d: pulse at stamp %0d, want %0d", ln, st[ln], bq[idx].stamp);
            end
            bq.delete(idx);
        end
    endtask

    task automatic check_pos(int ln);
        for (int i = 0; i < pq.size(); i++) begin
            if (pq[i].lane == ln && pq[i].stamp == st[ln]) begin
                checks++;
                if (pos_x(ln) != pq[i].a || pos_y(ln) != pq[i].b) begin
                    errors++;
                    $display("FAIL pos_lane%0d: at stamp %0d got (%0d,%0d), want (%0d,%0d)",
                             ln, st[ln], pos_x(ln), pos_y(ln), pq[i].a, pq[i].b);
                end
                pq.delete(i);
                break;
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic prev_v;
        int   run_st;
        int   run_len;
        prev_v  = 1'b0;
        run_st  = 0;
        run_len = 0;
        forever begin
            @(negedge i_Clk);
            if (vid[0] === 1'b1) begin
                if (!prev_v) begin
                    run_st  = st[0];
                    run_len = 0;
                end
                run_len++;
                prev_v = 1'b1;
            end else if (prev_v) begin
                prev_v = 1'b0;
                check_run(run_st, run_len);
            end
            for (int ln = 0; ln < 4; ln++) begin
                if (bnc[ln] === 1'b1) check_bounce(ln);
            end
            for (int ln = 1; ln < 4; ln++) check_pos(ln);
        end
    end

    initial begin : stimulus
        int fl;
        int f;
        int l;
        int k;

        // Lane 0: ball moves (100,50)->(102,52)->(104,54); frame 3 reset at line 20 restores
        // (100,50) with row restarting, so only rows 50,51 land on lines 70,71; then (102,52).
        push_ball(0, 100, 50);
        push_ball(1, 102, 52);
        push_ball(2, 104, 54);
        push_run(3, 70, 100);
        push_run(3, 71, 100);
        push_ball(4, 102, 52);

        // Lane 1: updates at frames 3 and 6; ticks for frames 9 and 12 fall in the pause; 15, 18 resume.
        for (int fr = 0; fr < 19; fr++) begin
            if (fr < 3)       push_pos(1, fr, 100, 50);
            else if (fr < 6)  push_pos(1, fr, 102, 52);
            else if (fr < 15) push_pos(1, fr, 104, 54);
            else if (fr < 18) push_pos(1, fr, 106, 56);
            else              push_pos(1, fr, 108, 58);
        end

        // Lane 2: 622 -> 624 (reflect) -> 622 -> 620.
        push_pos(2, 0, 622, 50);
        push_pos(2, 1, 624, 52);
        push_pos(2, 2, 622, 54);
        push_pos(2, 3, 620, 56);
        push_bnc(2, 1);

        // Lane 3: X reflects at tick 1, Y at tick 24, both reach 0 on tick 91 (one pulse).
        push_pos(3, 0, 617, 300);
        push_pos(3, 1, 624, 307);
        push_pos(3, 24, 463, 464);
        push_pos(3, 90, 1, 2);
        push_pos(3, 91, 0, 0);
        push_pos(3, 92, 7, 7);
        push_bnc(3, 1);
        push_bnc(3, 24);
        push_bnc(3, 91);

        for (int ln = 0; ln < 4; ln++) begin
            rstn[ln] = 1'b0;
            hr[ln]   = 1'b0;
            vr[ln]   = 1'b0;
            pau[ln]  = 1'b0;
            st[ln]   = -1;
        end
        repeat (3) @(posedge i_Clk);
        #1;
        for (int ln = 0; ln < 4; ln++) begin
            checks++;
            if (vid[ln] !== 1'b0) begin
                errors++;
                $display("FAIL reset_video_lane%0d: got %b, want 0", ln, vid[ln]);
            end
            checks++;
            if (bnc[ln] !== 1'b0) begin
                errors++;
                $display("FAIL reset_bounce_lane%0d: got %b, want 0", ln, bnc[ln]);
            end
        end

        for (int c = 0; c < TOTAL; c++) begin
            for (int ln = 0; ln < 4; ln++) begin
                fl = LEN[ln] * NL[ln];
                if (c < fl * NF[ln]) begin
                    f       = c / fl;
                    l       = (c % fl) / LEN[ln];
                    k       = c % LEN[ln];
                    hr[ln]  = (k == LEN[ln] - 1);
                    vr[ln]  = (k == LEN[ln] - 1) && (l == NL[ln] - 1);
                    st[ln]  = stamp(f, l, k);
                end else begin
                    hr[ln]  = 1'b0;
                    vr[ln]  = 1'b0;
                    st[ln]  = -1;
                end
                rstn[ln] = 1'b1;
            end
            rstn[0] = !(st[0] >= stamp(3, 20, 37) && st[0] <= stamp(3, 20, 38));
            pau[1]  = (st[1] >= stamp(9, 0, 0)) && (st[1] < stamp(15, 0, 0));
            @(posedge i_Clk);
            #1;
        end
        repeat (4) @(posedge i_Clk);
        #1;

        checks++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL video_missing: %0d runs never seen, first at stamp %0d", vq.size(), vq[0].stamp);
        end
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL pos_missing: %0d samples never taken, first lane%0d stamp %0d", pq.size(), pq[0].lane, pq[0].stamp);
        end
        checks++;
        if (bq.size() != 0) begin
            errors++;
            $display("FAIL bounce_missing: %0d pulses never seen, first lane%0d stamp %0d", bq.size(), bq[0].lane, bq[0].stamp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
